// File: rtl/reflex_frame_logger_pkg.sv
// Shared constants, frame layout indices and serializer state encodings
// for the reflex frame logger.
package reflex_frame_logger_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned EMG_W       = 18;
  localparam int unsigned FRAME_WORDS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam logic [7:0]  HDR_MAGIC   = 8'hA5;

  localparam logic [IDX_W-1:0] WIDX_HDR    = 3'd0;
  localparam logic [IDX_W-1:0] WIDX_POS1   = 3'd1;
  localparam logic [IDX_W-1:0] WIDX_VEL1   = 3'd2;
  localparam logic [IDX_W-1:0] WIDX_TQ1    = 3'd3;
  localparam logic [IDX_W-1:0] WIDX_TQ2    = 3'd4;
  localparam logic [IDX_W-1:0] WIDX_EMG1   = 3'd5;
  localparam logic [IDX_W-1:0] WIDX_EMG2   = 3'd6;
  localparam logic [IDX_W-1:0] WIDX_SPIKES = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  function automatic logic [WORD_W-1:0] sext_emg(input logic [EMG_W-1:0] v);
    return {{(WORD_W-EMG_W){v[EMG_W-1]}}, v};
  endfunction

endpackage

// File: rtl/reflex_frame_logger_sync_word_fifo.sv
// Single-clock word FIFO with registered read data, occupancy and empty flag.
module sync_word_fifo #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic          o_empty,
  output logic [AW:0]   o_word_count
);

  localparam int unsigned DEPTH = 32'(1) << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_empty;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic          w_full;
  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_count_nxt;

  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_wr        = i_wr_en & ~w_full;
  assign w_rd        = i_rd_en & ~r_empty;
  assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_rd_valid <= w_rd;
    end
  end

  // Storage array carries no reset; pointers alone define its contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_empty      = r_empty;
  assign o_word_count = r_count;

endmodule

// File: rtl/reflex_frame_logger.sv
// Captures one 8-word frame per dataValid rising edge and queues it in a word
// FIFO for host readout; frames that do not fit are dropped whole and counted.
module reflex_frame_logger
  import reflex_frame_logger_pkg::*;
#(
  parameter int unsigned NN = 8,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          dataValid,
  input  logic [31:0]   pos1,
  input  logic [31:0]   vel1,
  input  logic [31:0]   torque1,
  input  logic [31:0]   torque2,
  input  logic [17:0]   emg1,
  input  logic [17:0]   emg2,
  input  logic [NN:0]   spikes1,
  input  logic [NN:0]   spikes2,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic [AW:0]   word_count,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  localparam int unsigned DEPTH = 32'(1) << AW;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_dv_q;
  logic [15:0]       r_seq;
  logic [15:0]       r_drop;
  logic              r_overflow;
  logic [WORD_W-1:0] r_snap [FRAME_WORDS];

  state_t            w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [15:0]       w_seq_nxt;
  logic [15:0]       w_drop_nxt;
  logic              w_ovf_nxt;
  logic              w_accept;
  logic              w_wr_en;
  logic [WORD_W-1:0] w_wr_data;
  logic              w_start;
  logic              w_room;
  logic [15:0]       w_drop_inc;
  logic [AW:0]       w_word_count;

  assign w_start    = dataValid & ~r_dv_q & enable;
  assign w_room     = ((AW+1)'(DEPTH) - w_word_count) >= (AW+1)'(FRAME_WORDS);
  assign w_drop_inc = (r_drop == 16'hFFFF) ? r_drop : r_drop + 16'd1;

  // Serializer state and frame accounting registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_dv_q     <= 1'b1;
      r_seq      <= '0;
      r_drop     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_dv_q     <= dataValid;
      r_seq      <= w_seq_nxt;
      r_drop     <= w_drop_nxt;
      r_overflow <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_seq_nxt   = r_seq;
    w_drop_nxt  = r_drop;
    w_ovf_nxt   = r_overflow;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = r_snap[r_idx];
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_seq_nxt = r_seq + 16'd1;
          if (w_room) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WRITE;
            w_idx_nxt   = '0;
          end else begin
            w_drop_nxt = w_drop_inc;
            w_ovf_nxt  = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_wr_en   = 1'b1;
        w_idx_nxt = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(FRAME_WORDS - 1)) w_state_nxt = ST_IDLE;
        // A new block arriving mid-frame cannot be serialized in time.
        if (w_start) begin
          w_seq_nxt  = r_seq + 16'd1;
          w_drop_nxt = w_drop_inc;
          w_ovf_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot of the whole frame taken at the accepting edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FRAME_WORDS; i++) r_snap[i] <= '0;
    end else if (w_accept) begin
      r_snap[WIDX_HDR]    <= {HDR_MAGIC, r_drop[7:0], r_seq};
      r_snap[WIDX_POS1]   <= pos1;
      r_snap[WIDX_VEL1]   <= vel1;
      r_snap[WIDX_TQ1]    <= torque1;
      r_snap[WIDX_TQ2]    <= torque2;
      r_snap[WIDX_EMG1]   <= sext_emg(emg1);
      r_snap[WIDX_EMG2]   <= sext_emg(emg2);
      r_snap[WIDX_SPIKES] <= WORD_W'({spikes2, spikes1});
    end
  end

  sync_word_fifo #(
    .AW (AW),
    .DW (WORD_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_wr_en),
    .i_wr_data    (w_wr_data),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_empty      (empty),
    .o_word_count (w_word_count)
  );

  assign word_count = w_word_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_reflex_frame_logger.sv
// Self-checking bench for reflex_frame_logger: table-driven frames checked
// through a scoreboard queue, plus overflow, collision, enable and reset cases.
module tb_reflex_frame_logger;

  localparam int unsigned NN = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          dataValid;
  logic [31:0]   pos1, vel1, torque1, torque2;
  logic [17:0]   emg1, emg2;
  logic [NN:0]   spikes1, spikes2;
  logic          rd_en;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   word_count;
  logic          overflow;
  logic [15:0]   drop_count;

  reflex_frame_logger #(.NN(NN), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .dataValid  (dataValid),
    .pos1       (pos1),
    .vel1       (vel1),
    .torque1    (torque1),
    .torque2    (torque2),
    .emg1       (emg1),
    .emg2       (emg2),
    .spikes1    (spikes1),
    .spikes2    (spikes2),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .word_count (word_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pos1;
    logic [31:0] vel1;
    logic [31:0] tq1;
    logic [31:0] tq2;
    logic [17:0] emg1;
    logic [17:0] emg2;
    logic [8:0]  sp1;
    logic [8:0]  sp2;
    logic [31:0] exp_e1;
    logic [31:0] exp_e2;
    logic [31:0] exp_sp;
  } vec_t;

  localparam int MODE_IGNORED = 0;
  localparam int MODE_ACCEPT  = 1;
  localparam int MODE_DROP    = 2;

  vec_t        vecs [4];
  logic [31:0] exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_rx   = 0;
  logic [15:0] m_seq  = '0;
  logic [15:0] m_drop = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Pops one expected word per rd_valid beat.
  always @(posedge clk) begin : mon_blk
    logic [31:0] e;
    #1;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
        n_rx++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input vec_t v, input int mode);
    @(negedge clk);
    pos1 = v.pos1; vel1 = v.vel1; torque1 = v.tq1; torque2 = v.tq2;
    emg1 = v.emg1; emg2 = v.emg2; spikes1 = v.sp1; spikes2 = v.sp2;
    dataValid = 1'b1;
    if (mode == MODE_ACCEPT) begin
      exp_q.push_back({8'hA5, m_drop[7:0], m_seq});
      exp_q.push_back(v.pos1);
      exp_q.push_back(v.vel1);
      exp_q.push_back(v.tq1);
      exp_q.push_back(v.tq2);
      exp_q.push_back(v.exp_e1);
      exp_q.push_back(v.exp_e2);
      exp_q.push_back(v.exp_sp);
    end else if (mode == MODE_DROP) begin
      m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
    end
    if (mode != MODE_IGNORED) m_seq = m_seq + 16'd1;
    @(negedge clk);
    dataValid = 1'b0;
  endtask

  task automatic read_words(input int n);
    @(negedge clk);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rd_valid_after_rd_en", 32'(rd_valid), 32'd1);
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_empty"},      32'(empty),      32'd1);
    chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    chk({tag, "_rd_valid"},   32'(rd_valid),   32'd0);
    chk({tag, "_overflow"},   32'(overflow),   32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  initial begin
    int rx0;
    vecs[0] = '{pos1: 32'h3F800000, vel1: 32'h12345678, tq1: 32'h40000000, tq2: 32'hC0400000,
                emg1: 18'h3FFFB, emg2: 18'h00100, sp1: 9'd3, sp2: 9'd7,
                exp_e1: 32'hFFFFFFFB, exp_e2: 32'h00000100, exp_sp: 32'h00000E03};
    vecs[1] = '{pos1: 32'hBF800000, vel1: 32'h00000000, tq1: 32'h00000001, tq2: 32'h7F7FFFFF,
                emg1: 18'h1FFFF, emg2: 18'h20000, sp1: 9'h1FF, sp2: 9'h1FF,
                exp_e1: 32'h0001FFFF, exp_e2: 32'hFFFE0000, exp_sp: 32'h0003FFFF};
    vecs[2] = '{pos1: 32'hDEADBEEF, vel1: 32'hCAFEF00D, tq1: 32'h3F000000, tq2: 32'hBF000000,
                emg1: 18'h00000, emg2: 18'h3FFFF, sp1: 9'h000, sp2: 9'h100,
                exp_e1: 32'h00000000, exp_e2: 32'hFFFFFFFF, exp_sp: 32'h00020000};
    vecs[3] = '{pos1: 32'h00000000, vel1: 32'hFFFFFFFF, tq1: 32'h41200000, tq2: 32'hC1200000,
                emg1: 18'h00001, emg2: 18'h2AAAA, sp1: 9'h155, sp2: 9'h0AA,
                exp_e1: 32'h00000001, exp_e2: 32'hFFFEAAAA, exp_sp: 32'h00015555};

    reset = 1'b0; enable = 1'b1; dataValid = 1'b1; rd_en = 1'b0;
    pos1 = '0; vel1 = '0; torque1 = '0; torque2 = '0;
    emg1 = '0; emg2 = '0; spikes1 = '0; spikes2 = '0;

    // dataValid already high across reset release must not start a frame.
    idle(3);
    reset = 1'b1;
    idle(4);
    check_cleared("reset");
    chk("reset_rd_data", rd_data, 32'd0);
    dataValid = 1'b0;
    idle(3);
    chk("no_frame_after_release_empty", 32'(empty), 32'd1);
    chk("no_frame_after_release_count", 32'(word_count), 32'd0);

    for (int i = 0; i < 4; i++) begin
      pulse(vecs[i], MODE_ACCEPT);
      idle(10);
      chk("table_word_count", 32'(word_count), 32'd8);
      chk("table_not_empty", 32'(empty), 32'd0);
      read_words(8);
      idle(2);
      chk("table_drained_empty", 32'(empty), 32'd1);
    end

    // Fill the 16-word FIFO, then drop a frame for lack of space.
    @(negedge clk); reset = 1'b0; exp_q.delete(); m_seq = '0; m_drop = '0;
    idle(2); reset = 1'b1;
    idle(2);
    pulse(vecs[0], MODE_ACCEPT);
    idle(10);
    pulse(vecs[1], MODE_ACCEPT);
    idle(10);
    chk("full_word_count", 32'(word_count), 32'd16);
    pulse(vecs[2], MODE_DROP);
    idle(3);
    chk("ovf_word_count", 32'(word_count), 32'd16);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    chk("ovf_drop_count", 32'(drop_count), 32'd1);
    read_words(16);
    idle(2);
    chk("ovf_drained_empty", 32'(empty), 32'd1);
    chk("ovf_next_header_model", {8'hA5, m_drop[7:0], m_seq}, 32'hA5010003);
    pulse(vecs[3], MODE_ACCEPT);
    idle(10);
    read_words(8);

    // Second edge four clocks after the first collides with serialization.
    pulse(vecs[1], MODE_ACCEPT);
    idle(2);
    pulse(vecs[2], MODE_DROP);
    idle(10);
    chk("collide_drop_count", 32'(drop_count), 32'd2);
    chk("collide_word_count", 32'(word_count), 32'd8);
    chk("collide_overflow", 32'(overflow), 32'd1);
    read_words(8);

    // enable low: edges are ignored and seq does not advance.
    enable = 1'b0;
    pulse(vecs[0], MODE_IGNORED);
    idle(3);
    pulse(vecs[1], MODE_IGNORED);
    idle(10);
    chk("disabled_word_count", 32'(word_count), 32'd0);
    enable = 1'b1;
    pulse(vecs[2], MODE_ACCEPT);
    idle(10);
    read_words(8);

    // Reset sampled while the serializer is at word index 3.
    pulse(vecs[3], MODE_ACCEPT);
    idle(3);
    reset = 1'b0;
    exp_q.delete(); m_seq = '0; m_drop = '0;
    idle(2);
    reset = 1'b1;
    idle(2);
    check_cleared("midframe_reset");
    idle(12);
    chk("midframe_no_residual_empty", 32'(empty), 32'd1);
    chk("midframe_no_residual_count", 32'(word_count), 32'd0);
    pulse(vecs[0], MODE_ACCEPT);
    idle(10);
    read_words(8);

    // Continuous rd_en while two frames stream at the minimum period.
    rx0 = n_rx;
    @(negedge clk);
    rd_en = 1'b1;
    pulse(vecs[1], MODE_ACCEPT);
    idle(7);
    pulse(vecs[2], MODE_ACCEPT);
    idle(15);
    chk("stream_word_total", 32'(n_rx - rx0), 32'd16);
    chk("stream_drop_count", 32'(drop_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rd_en_on_empty_rd_valid", 32'(rd_valid), 32'd0);
    end
    @(negedge clk);
    rd_en = 1'b0;
    idle(2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
